// File: rtl/spm_pkg.sv
// rtl/spm_pkg.sv - shared types and sizing for the sequenced serial-parallel multiplier
// Define SPM_SIGNED_EN for a two's-complement multiply; unsigned otherwise.
package spm_pkg;

   typedef enum logic {IDLE, RUN} state_t;

`ifdef SPM_SIGNED_EN
   localparam bit SPM_SIGNED = 1'b1;
`else
   localparam bit SPM_SIGNED = 1'b0;
`endif

   function automatic int CNT_W(input int width);
      return $clog2(2 * width);
   endfunction

endpackage

// File: rtl/spm_csa.sv
// rtl/spm_csa.sv - one carry-save bit-slice of the serial-parallel multiplier
module spm_csa #(
   parameter bit TCMP = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   input  logic i_x,
   input  logic i_a_bit,
   input  logic i_y_in,
   output logic o_y
);

   logic r_s;
   logic r_c;
   logic w_pp;

   // r_s holds the upper neighbour's sum from the previous step (already shifted down).
   assign w_pp = TCMP ? ~(i_a_bit & i_x) : (i_a_bit & i_x);
   assign o_y  = w_pp ^ r_s ^ r_c;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s <= 1'b0;
         r_c <= 1'b0;
      end else if (i_clr) begin
         // Signed top slice starts with a 2^(W-1) bias cancelling the complemented sign terms.
         r_s <= TCMP;
         r_c <= 1'b0;
      end else if (i_en) begin
         r_s <= i_y_in;
         r_c <= (w_pp & r_s) | (w_pp & r_c) | (r_s & r_c);
      end
   end

endmodule

// File: rtl/spm_seq.sv
// rtl/spm_seq.sv - start/result sequencer around the CSA slice chain (SPM_SIGNED_EN selects signed)
module spm_seq
   import spm_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start_valid,
   output logic             o_start_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_p_valid,
   output logic             o_p_bit,
   output logic             o_p_last,
   input  logic             i_p_ready
);

   localparam int CW = CNT_W(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b_sh;
   logic [CW-1:0]    r_cnt;
   logic             w_accept;
   logic             w_adv;
   logic             w_fill;
   logic             w_is_last;
   logic [WIDTH-1:0] w_y;
   logic [WIDTH-1:0] w_y_in;

   assign w_accept  = (r_state == IDLE) & i_start_valid;
   assign w_adv     = (r_state == RUN) & i_p_ready;
   assign w_is_last = (r_cnt == LAST);
   assign w_fill    = SPM_SIGNED & r_b_sh[WIDTH-1];
   assign w_y_in    = {1'b0, w_y[WIDTH-1:1]};

   for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      spm_csa #(
         .TCMP (SPM_SIGNED && (i == WIDTH - 1))
      ) u_csa (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_en    (w_adv),
         .i_clr   (w_accept),
         .i_x     (r_b_sh[0]),
         .i_a_bit (r_a[i]),
         .i_y_in  (w_y_in[i]),
         .o_y     (w_y[i])
      );
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      o_start_ready = 1'b0;
      o_p_valid     = 1'b0;
      o_p_bit       = 1'b0;
      o_p_last      = 1'b0;
      case (r_state)
         IDLE: begin
            o_start_ready = 1'b1;
            if (i_start_valid) w_state_nxt = RUN;
         end
         RUN: begin
            o_p_valid = 1'b1;
            o_p_bit   = w_y[0];
            o_p_last  = w_is_last;
            if (i_p_ready && w_is_last) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_a    <= '0;
         r_b_sh <= '0;
         r_cnt  <= '0;
      end else if (w_accept) begin
         r_a    <= i_a;
         r_b_sh <= i_b;
         r_cnt  <= '0;
      end else if (w_adv) begin
         r_b_sh <= {w_fill, r_b_sh[WIDTH-1:1]};
         r_cnt  <= r_cnt + 1'b1;
      end
   end

endmodule

// File: doc/spm_seq.md
# spm_seq

Sequenced serial-parallel multiplier: wraps the carry-save-adder (CSA) slice chain of the `spm` datapath with a start/result handshake and a cycle counter. It captures a parallel multiplicand and a multiplier, feeds the multiplier LSB-first into the CSA chain, and streams the 2×WIDTH-bit product LSB-first. It sits directly around the `genblk1[*].csa` chain: it produces the serial `x` stream and collects the `y` output of slice 0.

## Interface
- WIDTH, 32, operand width; product is 2×WIDTH bits; ≥2.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_valid  in  1  operands presented.
- start_ready  out  1  block idle and able to accept; reset 1.
- a  in  WIDTH  multiplicand, captured on start handshake.
- b  in  WIDTH  multiplier, captured on start handshake.
- p_valid  out  1  p_bit valid; reset 0.
- p_bit  out  1  current product bit, LSB first; reset 0.
- p_last  out  1  marks product bit 2×WIDTH−1; reset 0.
- p_ready  in  1  consumer accepts p_bit.

## Operation
- FSM states: IDLE, RUN.
- IDLE: start_ready=1, p_valid=0.
  - On start_valid: capture a→a_q and b→b_sh.
  - Clear every CSA sum/carry flop, set cnt=0, go to RUN.
- RUN: start_ready=0, p_valid=1.
  - Serial input x = b_sh[0].
  - p_bit = slice-0 `y`, combinational from x and current CSA state.
- Advance only on p_valid && p_ready:
  - CSA flops update.
  - b_sh shifts right; fill bit is b_sh[WIDTH−1] (signed) or 0 (unsigned).
  - cnt increments.
- p_last = (cnt == 2×WIDTH−1). The handshake on that bit returns the FSM to IDLE.
- Stall (p_ready=0): CSA flops, b_sh and cnt hold; p_bit and p_last stay stable.
- start_valid while in RUN is ignored; operands are not captured; no overlap between products.
- cnt width is clog2(2×WIDTH); it never wraps within a product.
- Result equals a×b mod 2^(2×WIDTH), interpreted per the Configuration section.

## Timing
- Accept edge → p_valid=1 with bit 0 in the next cycle.
- With no stalls, bits 0..2W−1 take 2W consecutive cycles. start_ready returns 1 the cycle after the p_last handshake.
- Throughput: one product per 2W+1 cycles.
- Handshake rules:
  - p_valid never drops until the p_last handshake.
  - p_bit is glitch-free relative to registered state while stalled.
- rst asserted at any time, including mid-RUN:
  - Immediately state=IDLE, cnt=0, CSA flops=0, a_q=0, b_sh=0.
  - Outputs go to their reset values. The partial product is discarded.
- Reset release: the first handshake is possible on the first rising edge with rst low.

## Configuration
- SPM_SIGNED_EN defined: two's-complement multiply.
  - The top CSA slice uses the complement form for the a sign bit.
  - b_sh sign-extends during cycles W..2W−1.
- SPM_SIGNED_EN undefined: unsigned multiply.
  - All slices are identical.
  - b_sh zero-extends.

## Structure
- Package `spm_pkg`:
  - state enum {IDLE, RUN}.
  - CNT_W(WIDTH) function for the counter width.
- Sub-module `spm_csa`: one bit-slice, instantiated WIDTH times in a generate loop.
  - Ports: clk, rst, en, clr, x, a_bit, y_in, y.
  - Internal sum and carry flops.
  - Parameter TCMP for the signed top slice.
- Top holds the FSM, cnt, a_q, b_sh and handshake logic.

## Test plan
- WIDTH=8, unsigned, a=3, b=5, p_ready=1 → 16 bits LSB-first form 0x000F; p_last on cycle 16 after accept; start_ready=1 one cycle later.
- WIDTH=8, unsigned, a=0xFF, b=0xFF → 0xFE01; back-to-back second start 12×10 → 0x0078.
- WIDTH=8, SPM_SIGNED_EN, a=0xFF (−1), b=0x02 → 0xFFFE; a=0x80, b=0x80 → 0x4000.
- Stall: a=3, b=5, p_ready low for 3 cycles at bit 4 → p_bit/p_last held stable, product still 0x000F.
- start_valid pulsed mid-RUN with a=7, b=7 → ignored; current product unchanged; start_ready stays 0.
- rst asserted at bit 6 of a=0xFF×0xFF → next cycle p_valid=0, start_ready=1. A new 3×5 then yields 0x000F.
